// File: rtl/pq_binom_pkg.sv
// rtl/pq_binom_pkg.sv - shared types and constants for the binomial stream sampler
package pq_binom_pkg;
  localparam int RND_WIDTH  = 32;
  localparam int BUF_WIDTH  = 64;
  localparam int FILL_WIDTH = 7;

  typedef enum logic [1:0] {
    K2  = 2'b00,
    K4  = 2'b01,
    K8  = 2'b10,
    K16 = 2'b11
  } binom_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [5:0] k_of_mode(input binom_mode_t m);
    case (m)
      K2:      return 6'd2;
      K4:      return 6'd4;
      K8:      return 6'd8;
      default: return 6'd16;
    endcase
  endfunction
endpackage

// File: rtl/binom_bit_buffer.sv
// rtl/binom_bit_buffer.sv - 64-bit LSB-first shift buffer with fill count
// Pop shifts out the low bits; a push in the same cycle lands right after the surviving bits.
module binom_bit_buffer
  import pq_binom_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  push_i,
  input  logic [RND_WIDTH-1:0]  push_data_i,
  input  logic                  pop_i,
  input  logic [FILL_WIDTH-1:0] pop_bits_i,
  output logic [BUF_WIDTH-1:0]  data_o,
  output logic [FILL_WIDTH-1:0] fill_o
);
  logic [BUF_WIDTH-1:0]  buf_q, buf_d, base_buf;
  logic [FILL_WIDTH-1:0] fill_q, fill_d, base_fill;

  always_comb begin
    base_buf  = buf_q;
    base_fill = fill_q;
    if (pop_i) begin
      base_buf  = buf_q >> pop_bits_i;
      base_fill = fill_q - pop_bits_i;
    end
    buf_d  = base_buf;
    fill_d = base_fill;
    if (push_i) begin
      buf_d  = base_buf | ({{(BUF_WIDTH-RND_WIDTH){1'b0}}, push_data_i} << base_fill);
      fill_d = base_fill + 7'd32;
    end
    if (clr_i) begin
      buf_d  = '0;
      fill_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

  assign data_o = buf_q;
  assign fill_o = fill_q;
endmodule

// File: rtl/binom_stream_sampler.sv
// rtl/binom_stream_sampler.sv - centered-binomial sampler over a 32-bit random word stream
// Optional BINOM_STREAM_STATS_EN adds words_used, a saturating count of words accepted since start.
module binom_stream_sampler
  import pq_binom_pkg::*;
#(
  parameter int PARAM_Q    = 12289,
  parameter int COEF_WIDTH = 16,
  parameter int CNT_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [CNT_WIDTH-1:0]  num_samples,
  input  logic [RND_WIDTH-1:0]  rnd_data,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  output logic [COEF_WIDTH-1:0] coef_data,
  output logic                  coef_valid,
  input  logic                  coef_ready,
`ifdef BINOM_STREAM_STATS_EN
  output logic [31:0]           words_used,
`endif
  output logic                  busy,
  output logic                  done
);
  state_t                  state_q;
  binom_mode_t             mode_q;
  logic [CNT_WIDTH-1:0]    num_q, issued_q;
  logic [COEF_WIDTH-1:0]   coef_data_q, coef_n;
  logic                    coef_valid_q, busy_q, done_q;
  logic [BUF_WIDTH-1:0]    buf_data;
  logic [FILL_WIDTH-1:0]   fill, two_k;
  logic [5:0]              k;
  logic                    more, produce, accept, start_go;
  logic [15:0]             mask, a_bits, b_bits, hi_bits;
  logic [4:0]              pop_a, pop_b;

  assign k        = k_of_mode(mode_q);
  assign two_k    = {k, 1'b0};
  assign more     = issued_q < num_q;
  assign start_go = (state_q == IDLE) && start;
  assign produce  = (state_q == RUN) && (fill >= two_k) && more && (!coef_valid_q || coef_ready);
  // Ready depends on registers only so it never combinationally follows rnd_valid.
  assign rnd_ready = (state_q == RUN) && (fill <= 7'd32) && more;
  assign accept    = rnd_valid && rnd_ready;

  binom_bit_buffer u_buf (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (start_go),
    .push_i      (accept),
    .push_data_i (rnd_data),
    .pop_i       (produce),
    .pop_bits_i  (two_k),
    .data_o      (buf_data),
    .fill_o      (fill)
  );

  always_comb begin
    mask    = 16'((17'd1 << k) - 17'd1);
    hi_bits = 16'(buf_data >> k);
    a_bits  = buf_data[15:0] & mask;
    b_bits  = hi_bits & mask;
    pop_a   = 5'($countones(a_bits));
    pop_b   = 5'($countones(b_bits));
    if (pop_a >= pop_b) coef_n = COEF_WIDTH'(pop_a - pop_b);
    else                coef_n = COEF_WIDTH'(PARAM_Q) - COEF_WIDTH'(pop_b - pop_a);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mode_q       <= K2;
      num_q        <= '0;
      issued_q     <= '0;
      coef_data_q  <= '0;
      coef_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q   <= binom_mode_t'(mode);
            num_q    <= num_samples;
            issued_q <= '0;
            if (num_samples == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (produce) begin
            issued_q     <= issued_q + CNT_WIDTH'(1);
            coef_data_q  <= coef_n;
            coef_valid_q <= 1'b1;
          end else if (coef_ready) begin
            coef_valid_q <= 1'b0;
          end
          if ((issued_q == num_q) && coef_valid_q && coef_ready) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign coef_data  = coef_data_q;
  assign coef_valid = coef_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

`ifdef BINOM_STREAM_STATS_EN
  logic [31:0] words_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  words_q <= '0;
    else if (start_go)                          words_q <= '0;
    else if (accept && (words_q != 32'hFFFF_FFFF)) words_q <= words_q + 32'd1;
  end

  assign words_used = words_q;
`endif
endmodule
